// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU controls and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_ADDIEXEC = 4'd8,
    S_ADDIWB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucontrol_t;

  // ALU_NONE yields alucontrol 000 in states that do not use the ALU.
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'b00,
    ALUOP_ADD   = 2'b01,
    ALUOP_SUB   = 2'b10,
    ALUOP_FUNCT = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic     pcwrite;
    logic     branch;
    logic     bne_sel;
    logic     memwrite;
    logic     irwrite;
    logic     regwrite;
    logic     iord;
    logic     memtoreg;
    logic     regdst;
    logic     alusrca;
    alusrcb_t alusrcb;
    pcsrc_t   pcsrc;
    aluop_t   aluop;
  } ctrl_t;

  // States in which an instruction completes and is counted as retired.
  function automatic logic retires(state_t s);
    return s inside {S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP};
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// enables, mux selects, trap flag and retire count out.
interface mips_multicycle_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pcen;
  logic        memwrite;
  logic        irwrite;
  logic        regwrite;
  logic        iord;
  logic        memtoreg;
  logic        regdst;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, instret
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, instret
  );
endinterface

// File: rtl/mips_aludec.sv
// ALU decoder: maps the controller's ALU request and the R-type funct field
// onto an alucontrol code, and flags whether funct names a supported op.
module mips_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  aluop_t     aluop,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  alucontrol_t funct_op;

  always_comb begin
    funct_op    = ALU_AND;
    funct_valid = 1'b1;
    case (funct)
      FUNCT_ADD: funct_op = ALU_ADD;
      FUNCT_SUB: funct_op = ALU_SUB;
      FUNCT_AND: funct_op = ALU_AND;
      FUNCT_OR:  funct_op = ALU_OR;
      FUNCT_SLT: funct_op = ALU_SLT;
      default:   funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_op;
      default:     alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with a sticky illegal trap and instret.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic clk,
  input  logic res,
  mips_multicycle_ctrl_if.master ctrl
);

  state_t      state_q, state_d;
  ctrl_t       cs, cs_gated;
  logic        funct_valid;
  logic        illegal_q;
  logic [31:0] instret_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // NOTE: each combinational block assigns a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_ADDI:        state_d = S_ADDIEXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (ctrl.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = funct_valid ? S_ALUWB : S_TRAP;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    cs = '0;
    unique case (state_q)
      S_FETCH: begin
        cs.irwrite = 1'b1;
        cs.alusrcb = SRCB_FOUR;
        cs.aluop   = ALUOP_ADD;
        cs.pcsrc   = PCSRC_ALU;
        cs.pcwrite = 1'b1;
      end
      S_DECODE: begin
        cs.alusrcb = SRCB_IMMSH;
        cs.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        cs.alusrca = 1'b1;
        cs.alusrcb = SRCB_IMM;
        cs.aluop   = ALUOP_ADD;
      end
      S_MEMRD: cs.iord = 1'b1;
      S_MEMWB: begin
        cs.memtoreg = 1'b1;
        cs.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cs.iord     = 1'b1;
        cs.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        cs.alusrca = 1'b1;
        cs.alusrcb = SRCB_B;
        cs.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cs.regdst   = 1'b1;
        cs.regwrite = 1'b1;
      end
      S_ADDIWB: cs.regwrite = 1'b1;
      S_BRANCH: begin
        cs.alusrca = 1'b1;
        cs.alusrcb = SRCB_B;
        cs.aluop   = ALUOP_SUB;
        cs.pcsrc   = PCSRC_ALUOUT;
        cs.branch  = 1'b1;
        cs.bne_sel = (ctrl.op == OP_BNE);
      end
      S_JUMP: begin
        cs.pcsrc   = PCSRC_JUMP;
        cs.pcwrite = 1'b1;
      end
      default: cs = '0;
    endcase
  end

  // Reset returns the state to FETCH asynchronously, but FETCH asserts writes,
  // so every control is held low for as long as res is high.
  always_comb begin
    cs_gated = cs;
    if (res) cs_gated = '0;
  end

  mips_aludec u_aludec (
    .funct       (ctrl.funct),
    .aluop       (cs_gated.aluop),
    .alucontrol  (ctrl.alucontrol),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      illegal_q <= illegal_q | (state_d == S_TRAP);
      if (retires(state_q)) instret_q <= instret_q + 32'd1;
    end
  end

  // Branch taken-ness is resolved from the live zero flag, never registered.
  assign ctrl.pcen     = cs_gated.pcwrite |
                         (cs_gated.branch & (ctrl.zero ^ cs_gated.bne_sel));
  assign ctrl.memwrite = cs_gated.memwrite;
  assign ctrl.irwrite  = cs_gated.irwrite;
  assign ctrl.regwrite = cs_gated.regwrite;
  assign ctrl.iord     = cs_gated.iord;
  assign ctrl.memtoreg = cs_gated.memtoreg;
  assign ctrl.regdst   = cs_gated.regdst;
  assign ctrl.alusrca  = cs_gated.alusrca;
  assign ctrl.alusrcb  = cs_gated.alusrcb;
  assign ctrl.pcsrc    = cs_gated.pcsrc;
  assign ctrl.illegal  = illegal_q;
  assign ctrl.instret  = instret_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction, per-cycle
// expected control words compared every cycle against the outputs.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl dut (.clk(clk), .res(res), .ctrl(bus));

  typedef enum {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_BADOP, C_BADFN} cls_t;

  typedef struct packed {
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } obs_t;

  obs_t obs;
  assign obs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
                bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
                bus.alucontrol, bus.illegal};

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_instret = '0;
  logic [5:0]  valid_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic logic [5:0] op_of(cls_t c);
    case (c)
      C_LW:    return 6'b100011;
      C_SW:    return 6'b101011;
      C_ADDI:  return 6'b001000;
      C_BEQ:   return 6'b000100;
      C_BNE:   return 6'b000101;
      C_J:     return 6'b000010;
      C_BADOP: return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int cycles_of(cls_t c);
    case (c)
      C_LW:                return 5;
      C_SW, C_R, C_ADDI:   return 4;
      C_BADOP:             return 2;
      default:             return 3;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction of class c.
  function automatic obs_t expect_cycle(cls_t c, int k, logic z, logic [5:0] f);
    obs_t e;
    e = '0;
    if (k == 0) begin
      e.irwrite = 1; e.alusrcb = 2'b01; e.alucontrol = 3'b010; e.pcen = 1;
    end else if (k == 1) begin
      e.alusrcb = 2'b11; e.alucontrol = 3'b010;
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
          else if (c == C_LW && k == 3) e.iord = 1;
          else if (c == C_LW) begin e.memtoreg = 1; e.regwrite = 1; end
          else begin e.iord = 1; e.memwrite = 1; end
        end
        C_R, C_BADFN: begin
          if (k == 2) begin e.alusrca = 1; e.alusrcb = 2'b00; e.alucontrol = alu_for(f); end
          else begin e.regdst = 1; e.regwrite = 1; end
        end
        C_ADDI: begin
          if (k == 2) begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
          else e.regwrite = 1;
        end
        C_BEQ, C_BNE: begin
          e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
          e.pcen = (c == C_BEQ) ? z : ~z;
        end
        C_J: begin e.pcsrc = 2'b10; e.pcen = 1; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic check_ctrl(input string tag, input obs_t exp, input obs_t mask);
    vectors++;
    assert ((obs & mask) === (exp & mask)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs & mask, exp & mask);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
    vectors++;
    assert (bus.instret === exp) else begin
      miscompares++;
      $error("FAIL %s: instret observed %0d expected %0d", tag, bus.instret, exp);
    end
  endtask

  // zmode: 0/1 force zero, 2 random.
  task automatic step(input cls_t c, input int k, input logic [5:0] f, input int zmode);
    logic z;
    obs_t exp, mask;
    z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
    bus.op = op_of(c); bus.funct = f; bus.zero = z;
    @(negedge clk);
    exp  = expect_cycle(c, k, z, f);
    mask = '1;
    if (c == C_BADFN && k == 2) mask.alucontrol = '0;
    check_ctrl($sformatf("%s.c%0d", c.name(), k), exp, mask);
    check_cnt($sformatf("%s.c%0d.cnt", c.name(), k), model_instret);
  endtask

  task automatic run_instr(input cls_t c, input logic [5:0] f, input int zmode);
    for (int k = 0; k < cycles_of(c); k++) begin
      step(c, k, f, zmode);
      @(posedge clk); #1;
    end
    if (c != C_BADOP && c != C_BADFN) model_instret++;
  endtask

  task automatic do_reset();
    res = 1'b1;
    bus.op = 6'($urandom); bus.funct = 6'($urandom); bus.zero = 1'b1;
    @(negedge clk);
    check_ctrl("reset_ctrl", '0, '1);
    check_cnt("reset_cnt", 32'd0);
    @(posedge clk); #1;
    res = 1'b0;
    model_instret = '0;
  endtask

  task automatic trap_hold(input int n);
    obs_t exp;
    exp = '0;
    exp.illegal = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.op = 6'($urandom); bus.funct = 6'($urandom); bus.zero = 1'($urandom);
      @(negedge clk);
      check_ctrl($sformatf("trap.c%0d", i), exp, '1);
      check_cnt($sformatf("trap.c%0d.cnt", i), model_instret);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    res = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    #2;
    do_reset();

    // Directed: one of each instruction, both branch outcomes.
    run_instr(C_LW, 6'b000000, 2);
    run_instr(C_R, 6'b100010, 2);
    run_instr(C_BEQ, 6'b000000, 1);
    run_instr(C_BEQ, 6'b000000, 0);
    run_instr(C_BNE, 6'b000000, 1);
    run_instr(C_BNE, 6'b000000, 0);
    run_instr(C_J, 6'b000000, 2);
    run_instr(C_ADDI, 6'b000000, 2);
    run_instr(C_SW, 6'b000000, 2);

    // Randomized legal instruction stream.
    for (int i = 0; i < 60; i++) begin
      cls_t c;
      c = cls_t'($urandom_range(0, 6));
      run_instr(c, valid_fn[$urandom_range(0, 4)], 2);
    end

    // Illegal opcode trap, then reset clears it.
    run_instr(C_BADOP, 6'b000000, 2);
    trap_hold(20);
    do_reset();

    // Illegal funct trap.
    run_instr(C_ADDI, 6'b000000, 2);
    run_instr(C_BADFN, 6'b000000, 2);
    trap_hold(20);
    do_reset();

    // Reset asserted during the store cycle of sw.
    run_instr(C_ADDI, 6'b000000, 2);
    for (int k = 0; k < 3; k++) begin
      step(C_SW, k, 6'b000000, 2);
      @(posedge clk); #1;
    end
    step(C_SW, 3, 6'b000000, 2);
    res = 1'b1;
    #1;
    check_ctrl("sw_abort", '0, '1);
    check_cnt("sw_abort_cnt", 32'd0);
    @(posedge clk); #1;
    res = 1'b0;
    model_instret = '0;
    run_instr(C_LW, 6'b000000, 2);
    run_instr(C_R, 6'b101010, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
